debug_slave_cmd_decoder: RTL and testbench

DEBUG_SLAVE_CMD_DECODER -- requirements
Module: debug_slave_cmd_decoder

---
 rtl/debug_slave_cmd_decoder.sv | 139 +++++++++++++
 tb/tb_debug_slave_cmd_decoder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_slave_cmd_decoder.sv
// Decodes virtual-JTAG update-IR/update-DR strobes into per-channel action pulses in the clk domain.
// Strobe edges reach the outputs SYNC_STAGES edges after first sampled high; a held command blocks new ones (overrun).
module debug_slave_cmd_decoder #(
  parameter int DATA_W      = 38,
  parameter int IR_W        = 2,
  parameter int NUM_CH      = 4,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IR_W-1:0]   ir_in,
  input  logic [DATA_W-1:0] sr,
  input  logic              vs_uir,
  input  logic              vs_udr,
  input  logic              cmd_ready,
  output logic [DATA_W-1:0] jdo,
  output logic [IR_W-1:0]   ir_q,
  output logic [NUM_CH-1:0] take_action,
  output logic [NUM_CH-1:0] take_no_action,
  output logic              cmd_valid,
  output logic              overrun,
  output logic              bad_ir
);

  typedef enum logic {IDLE, BUSY} state_t;

  logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q, fill_q;
  logic                   uir_prev_q, udr_prev_q, uir_arm_q, udr_arm_q;
  logic                   uir_p, udr_p, ir_ok;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      jdo_q, jdo_d;
  logic [IR_W-1:0]        ir_qq;
  logic [NUM_CH-1:0]      act_q, act_d, noact_q, noact_d;
  logic                   valid_q, valid_d, ovr_q, ovr_d, bad_q, bad_d;

  // fill_q marks when the sync chain holds real post-reset samples; an edge only
  // counts once a genuine low has been seen, so a level held across reset is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uir_sync_q <= '0;
      udr_sync_q <= '0;
      fill_q     <= '0;
      uir_prev_q <= 1'b0;
      udr_prev_q <= 1'b0;
      uir_arm_q  <= 1'b0;
      udr_arm_q  <= 1'b0;
    end else begin
      uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
      if (fill_q[SYNC_STAGES-1] && !uir_sync_q[SYNC_STAGES-1]) uir_arm_q <= 1'b1;
      if (fill_q[SYNC_STAGES-1] && !udr_sync_q[SYNC_STAGES-1]) udr_arm_q <= 1'b1;
    end
  end

  assign uir_p = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q & uir_arm_q;
  assign udr_p = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q & udr_arm_q;
  assign ir_ok = ({1'b0, ir_qq} < (IR_W+1)'(NUM_CH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (udr_p && ir_ok) state_d = BUSY;
      BUSY:    if (cmd_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    jdo_d   = jdo_q;
    act_d   = '0;
    noact_d = '0;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    bad_d   = bad_q;
    case (state_q)
      IDLE: begin
        if (udr_p) begin
          if (ir_ok) begin
            jdo_d   = sr;
            valid_d = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
              if (ir_qq == IR_W'(c)) begin
                if (sr[ACT_BIT]) act_d[c]   = 1'b1;
                else             noact_d[c] = 1'b1;
              end
            end
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      BUSY: begin
        if (udr_p)     ovr_d   = 1'b1;
        if (cmd_ready) valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // ir_qq updates after this cycle's decode, so a coincident update-DR uses the old IR
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jdo_q   <= '0;
      ir_qq   <= '0;
      act_q   <= '0;
      noact_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      jdo_q   <= jdo_d;
      act_q   <= act_d;
      noact_q <= noact_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      bad_q   <= bad_d;
      if (uir_p) ir_qq <= ir_in;
    end
  end

  assign jdo            = jdo_q;
  assign ir_q           = ir_qq;
  assign take_action    = act_q;
  assign take_no_action = noact_q;
  assign cmd_valid      = valid_q;
  assign overrun        = ovr_q;
  assign bad_ir         = bad_q;

endmodule

// File: tb/tb_debug_slave_cmd_decoder.sv
// Bench for debug_slave_cmd_decoder: a default instance and a NUM_CH=3 instance share stimulus and are
// checked each cycle against a command-level model, plus literal expectations at key points.
module tb_debug_slave_cmd_decoder;

  localparam int SYNC = 2;
  localparam int HMAX = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ir_in = '0;
  logic [37:0] sr = '0;
  logic        vs_uir = 1'b0, vs_udr = 1'b0, cmd_ready = 1'b0;

  logic [37:0] jdo4, jdo3;
  logic [1:0]  irq4, irq3;
  logic [3:0]  ta4, tna4;
  logic [2:0]  ta3, tna3;
  logic        cv4, ov4, bad4, cv3, ov3, bad3;

  debug_slave_cmd_decoder dut4 (
    .clk(clk), .reset(rst), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .cmd_ready(cmd_ready), .jdo(jdo4), .ir_q(irq4), .take_action(ta4), .take_no_action(tna4),
    .cmd_valid(cv4), .overrun(ov4), .bad_ir(bad4));

  debug_slave_cmd_decoder #(.NUM_CH(3)) dut3 (
    .clk(clk), .reset(rst), .ir_in(ir_in), .sr(sr), .vs_uir(vs_uir), .vs_udr(vs_udr),
    .cmd_ready(cmd_ready), .jdo(jdo3), .ir_q(irq3), .take_action(ta3), .take_no_action(tna3),
    .cmd_valid(cv3), .overrun(ov3), .bad_ir(bad3));

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Command-level model: input samples per post-reset edge, a rise counts when a low sample
  // precedes a high one, and its effect lands SYNC edges after the high sample.
  bit          udr_h [HMAX];
  bit          uir_h [HMAX];
  int          n = 0;
  int          nch [2] = '{4, 3};
  logic [37:0] m_jdo   [2];
  logic [1:0]  m_ir    [2];
  logic [3:0]  m_act   [2];
  logic [3:0]  m_noact [2];
  logic        m_valid [2];
  logic        m_ovr   [2];
  logic        m_bad   [2];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      n = 0;
      for (int d = 0; d < 2; d++) begin
        m_jdo[d] = '0; m_ir[d] = '0; m_act[d] = '0; m_noact[d] = '0;
        m_valid[d] = 1'b0; m_ovr[d] = 1'b0; m_bad[d] = 1'b0;
      end
    end else begin
      int  j;
      bit  udr_e, uir_e;
      if (n < HMAX) begin
        udr_h[n] = vs_udr;
        uir_h[n] = vs_uir;
      end
      j = n - SYNC;
      udr_e = (j >= 1 && j < HMAX) && udr_h[j] && !udr_h[j-1];
      uir_e = (j >= 1 && j < HMAX) && uir_h[j] && !uir_h[j-1];
      for (int d = 0; d < 2; d++) begin
        m_act[d] = '0;
        m_noact[d] = '0;
        if (!m_valid[d]) begin
          if (udr_e) begin
            if (int'(m_ir[d]) < nch[d]) begin
              m_jdo[d] = sr;
              if (sr[34]) m_act[d][m_ir[d]] = 1'b1;
              else        m_noact[d][m_ir[d]] = 1'b1;
              m_valid[d] = 1'b1;
            end else begin
              m_bad[d] = 1'b1;
            end
          end
        end else begin
          if (udr_e) m_ovr[d] = 1'b1;
          if (cmd_ready) m_valid[d] = 1'b0;
        end
        if (uir_e) m_ir[d] = ir_in;
      end
      n++;
    end
  end

  function automatic logic [63:0] mpack(input int d);
    return {13'b0, m_jdo[d], m_ir[d], m_act[d], m_noact[d], m_valid[d], m_ovr[d], m_bad[d]};
  endfunction

  wire [63:0] pack4 = {13'b0, jdo4, irq4, ta4, tna4, cv4, ov4, bad4};
  wire [63:0] pack3 = {13'b0, jdo3, irq3, 1'b0, ta3, 1'b0, tna3, cv3, ov3, bad3};

  always @(negedge clk) begin
    if (!rst) begin
      chk("cycle_dut4", pack4, mpack(0));
      chk("cycle_dut3", pack3, mpack(1));
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic uir_load(input logic [1:0] v);
    ir_in = v; vs_uir = 1'b1; cyc(4);
    vs_uir = 1'b0; cyc(4);
  endtask

  task automatic release_cmd();
    cmd_ready = 1'b1; cyc(1);
    cmd_ready = 1'b0; cyc(3);
  endtask

  initial begin
    cyc(3);
    chk("reset_dut4", pack4, 64'd0);
    chk("reset_dut3", pack3, 64'd0);
    #2 rst = 1'b0;
    cyc(6);

    // action on channel 1, exact latency
    uir_load(2'd1);
    chk("ir_load_1", {62'b0, irq4}, 64'd1);
    sr = 38'h04_0000_1234; vs_udr = 1'b1;
    cyc(1); chk("act_lat_e0", {60'b0, ta4}, 64'd0);
    cyc(1); chk("act_lat_e1", {60'b0, ta4}, 64'd0);
    cyc(1); chk("act_pulse", {60'b0, ta4}, 64'b0010);
    chk("act_jdo", {26'b0, jdo4}, 64'h04_0000_1234);
    chk("act_valid", {63'b0, cv4}, 64'd1);
    cyc(1); chk("act_one_cycle", {60'b0, ta4}, 64'd0);
    chk("act_valid_held", {63'b0, cv4}, 64'd1);
    vs_udr = 1'b0; cyc(2);
    cmd_ready = 1'b1; cyc(1);
    chk("ready_clears", {63'b0, cv4}, 64'd0);
    cmd_ready = 1'b0; cyc(3);

    // no-action on channel 0
    uir_load(2'd0);
    sr = 38'h00_0000_00AB; vs_udr = 1'b1;
    cyc(3); chk("noact_pulse", {60'b0, tna4}, 64'b0001);
    chk("noact_no_act", {60'b0, ta4}, 64'd0);
    cyc(2); vs_udr = 1'b0;
    cmd_ready = 1'b1; cyc(1);
    chk("noact_ready_clears", {63'b0, cv4}, 64'd0);
    cmd_ready = 1'b0; cyc(3);

    // overrun while a command is held
    sr = 38'h04_0000_5555; vs_udr = 1'b1; cyc(4);
    vs_udr = 1'b0; cyc(3);
    sr = 38'h00_1111_2222; vs_udr = 1'b1; cyc(4);
    chk("ovr_flag", {63'b0, ov4}, 64'd1);
    chk("ovr_jdo_frozen", {26'b0, jdo4}, 64'h04_0000_5555);
    chk("ovr_valid_held", {63'b0, cv4}, 64'd1);
    vs_udr = 1'b0; cyc(3);
    release_cmd();

    // ir 3: valid for 4 channels, bad for 3
    uir_load(2'd3);
    sr = 38'h04_0000_0077; vs_udr = 1'b1; cyc(4);
    chk("bad_ir_flag", {63'b0, bad3}, 64'd1);
    chk("bad_ir_no_valid", {63'b0, cv3}, 64'd0);
    chk("bad_ir_ok_on_4ch", {63'b0, bad4}, 64'd0);
    chk("ch3_valid_on_4ch", {63'b0, cv4}, 64'd1);
    vs_udr = 1'b0; cyc(3);
    release_cmd();

    // coincident update-IR and update-DR: decode uses old ir (0)
    uir_load(2'd0);
    ir_in = 2'd2; sr = 38'h04_0000_0039; vs_uir = 1'b1; vs_udr = 1'b1;
    cyc(3); chk("coinc_pulse_ch0", {60'b0, ta4}, 64'b0001);
    chk("coinc_ir_new", {62'b0, irq4}, 64'd2);
    cyc(2); vs_uir = 1'b0; vs_udr = 1'b0; cyc(3);
    release_cmd();

    // reset while busy with update-DR held high
    sr = 38'h04_0000_0ABC; vs_udr = 1'b1; cyc(4);
    chk("busy_before_reset", {63'b0, cv4}, 64'd1);
    #2 rst = 1'b1;
    #1 chk("async_reset_dut4", pack4, 64'd0);
    chk("async_reset_dut3", pack3, 64'd0);
    cyc(2);
    #2 rst = 1'b0;
    cyc(10);
    chk("held_level_no_cmd", {63'b0, cv4}, 64'd0);
    vs_udr = 1'b0; cyc(4);
    vs_udr = 1'b1; cyc(4);
    chk("new_edge_cmd", {63'b0, cv4}, 64'd1);
    vs_udr = 1'b0; cyc(3);
    release_cmd();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
